// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the multiply sequencer state type.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_LT  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu.sv
// Combinational pipeline ALU shared between the EX stage and the multiply sequencer.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    src_a,
    input  logic [DATA_WIDTH-1:0]    src_b,
    input  logic [OPCODE_LENGTH-1:0] alu_op,
    output logic [DATA_WIDTH-1:0]    result
);

    always_comb begin
        result = '0;
        case (alu_op)
            OPCODE_LENGTH'(ALU_AND): result = src_a & src_b;
            OPCODE_LENGTH'(ALU_ADD): result = src_a + src_b;
            OPCODE_LENGTH'(ALU_EQ):  result = DATA_WIDTH'(src_a == src_b);
            OPCODE_LENGTH'(ALU_LT):  result = DATA_WIDTH'($signed(src_a) < $signed(src_b));
            default:                 result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the shared ALU for each partial-product add.
// Produces the low DATA_WIDTH bits of MulA*MulB.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    MulA,
    input  logic [DATA_WIDTH-1:0]    MulB,
    output logic                     ready,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    Product,
    output logic                     AluReq,
    input  logic                     AluGnt,
    output logic [DATA_WIDTH-1:0]    AluSrcA,
    output logic [DATA_WIDTH-1:0]    AluSrcB,
    output logic [OPCODE_LENGTH-1:0] AluOperation,
    input  logic [DATA_WIDTH-1:0]    AluResult
);

    mul_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] product_q, product_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
        end else begin
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
        end
    end

    // Next state and datapath update; a requested add with no grant holds everything
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = MulA;
                    mplier_d = MulB;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q == '0) begin
                    product_d = acc_q;
                    state_d   = DONE;
                end else if (!mplier_q[0] || AluGnt) begin
                    if (mplier_q[0]) begin
                        acc_d = AluResult;
                    end
                    mcand_d  = {mcand_q[DATA_WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[DATA_WIDTH-1:1]};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs; ALU operands are parked at zero/AND whenever no add is requested
    always_comb begin
        ready        = (state_q == IDLE);
        done         = (state_q == DONE);
        AluReq       = 1'b0;
        AluSrcA      = '0;
        AluSrcB      = '0;
        AluOperation = OPCODE_LENGTH'(ALU_AND);
        if ((state_q == RUN) && mplier_q[0]) begin
            AluReq       = 1'b1;
            AluSrcA      = acc_q;
            AluSrcB      = mcand_q;
            AluOperation = OPCODE_LENGTH'(ALU_ADD);
        end
    end

    assign Product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq driving a real ALU in the loop.
module tb_alu_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] MulA;
    logic [31:0] MulB;
    logic        ready;
    logic        done;
    logic [31:0] Product;
    logic        AluReq;
    logic        AluGnt;
    logic [31:0] AluSrcA;
    logic [31:0] AluSrcB;
    logic [3:0]  AluOperation;
    logic [31:0] AluResult;

    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];

    alu_mul_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .MulA(MulA), .MulB(MulB),
        .ready(ready), .done(done), .Product(Product), .AluReq(AluReq),
        .AluGnt(AluGnt), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
        .AluOperation(AluOperation), .AluResult(AluResult)
    );

    alu #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) u_alu (
        .src_a(AluSrcA), .src_b(AluSrcB), .alu_op(AluOperation), .result(AluResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every done pulse must match the oldest outstanding expected product
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                check("product", Product, exp_q.pop_front());
            end
        end
    end

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input int stalls, input bit poke_start);
        logic [31:0] m_acc, m_mcand, m_mplier;
        int k, ones, cyc, reqs, stalls_left, exp_cyc;
        k = 0;
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) begin
                k = i + 1;
                ones++;
            end
        end
        exp_cyc = k + 2 + stalls;
        check("ready_idle", 32'(ready), 32'd1);
        MulA  = a;
        MulB  = b;
        start = 1'b1;
        exp_q.push_back(a * b);
        step();
        start = 1'b0;
        check("ready_busy", 32'(ready), 32'd0);
        m_acc = '0;
        m_mcand = a;
        m_mplier = b;
        cyc = 1;
        reqs = 0;
        stalls_left = stalls;
        while (!done && cyc < 80) begin
            if (poke_start && cyc == 2) begin
                start = 1'b1;
                MulA  = 32'h0000_DEAD;
                MulB  = 32'h0000_00FF;
            end else begin
                start = 1'b0;
            end
            check("alu_req", 32'(AluReq), 32'(m_mplier[0]));
            if (AluReq) begin
                reqs++;
                check("src_a", AluSrcA, m_acc);
                check("src_b", AluSrcB, m_mcand);
                check("alu_op", 32'(AluOperation), 32'h2);
            end else begin
                check("alu_op_idle", 32'(AluOperation), 32'h0);
            end
            if (AluReq && stalls_left > 0) begin
                AluGnt = 1'b0;
                stalls_left--;
            end else begin
                AluGnt = 1'b1;
                if (m_mplier != 0) begin
                    if (m_mplier[0]) m_acc = m_acc + m_mcand;
                    m_mcand  = m_mcand << 1;
                    m_mplier = m_mplier >> 1;
                end
            end
            step();
            cyc++;
        end
        start  = 1'b0;
        AluGnt = 1'b0;
        if (!done) begin
            check("done_timeout", 32'(done), 32'd1);
        end else begin
            check("done_cycle", 32'(cyc), 32'(exp_cyc));
            check("req_cycles", 32'(reqs), 32'(ones + stalls));
        end
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after", 32'(ready), 32'd1);
        check("product_held", Product, a * b);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset  = 1'b1;
        start  = 1'b0;
        MulA   = '0;
        MulB   = '0;
        AluGnt = 1'b0;
        repeat (2) step();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", Product, 32'd0);
        check("rst_req", 32'(AluReq), 32'd0);
        check("rst_src_a", AluSrcA, 32'd0);
        check("rst_src_b", AluSrcB, 32'd0);
        check("rst_op", 32'(AluOperation), 32'd0);
        reset = 1'b0;
        step();

        run_mul(32'd7, 32'd6, 0, 1'b0);
        run_mul(32'h0000_1234, 32'd0, 0, 1'b0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_mul(32'd3, 32'd5, 4, 1'b0);
        run_mul(32'd10, 32'd20, 0, 1'b1);
        repeat (40) step();

        // Abandon a multiply mid-flight via reset
        MulA  = 32'd100;
        MulB  = 32'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_product", Product, 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_req", 32'(AluReq), 32'd0);
        step();
        reset = 1'b0;
        repeat (40) step();
        run_mul(32'd2, 32'd2, 0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            run_mul($urandom, $urandom, n % 3, 1'b0);
        end

        repeat (5) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Iterative shift-and-add multiplier sequencer that time-shares the pipeline's single ALU through a request/grant handshake. It computes the low DATA_WIDTH bits of an unsigned product, issuing one ALU ADD per set multiplier bit, and sits beside the EX stage. An external mux routes the ALU operands to this block while its grant is high.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU Operation width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request a multiply; sampled only when ready=1
- MulA  in  DATA_WIDTH  multiplicand, captured on accepted start
- MulB  in  DATA_WIDTH  multiplier, captured on accepted start
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse; Product valid
- Product  out  DATA_WIDTH  (MulA*MulB) mod 2^DATA_WIDTH; held until next done
- AluReq  out  1  sequencer needs the ALU this cycle
- AluGnt  in  1  ALU operands routed from this block this cycle
- AluSrcA  out  DATA_WIDTH  ALU operand A
- AluSrcB  out  DATA_WIDTH  ALU operand B
- AluOperation  out  OPCODE_LENGTH  ALU opcode
- AluResult  in  DATA_WIDTH  combinational ALU result

## Operation
- Registers: acc, mcand, mplier (DATA_WIDTH each), state, Product.
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start, load acc=0, mcand=MulA, mplier=MulB, and go to RUN.
- RUN, mplier==0: go to DONE with Product<=acc.
- RUN, mplier[0]==0: mcand<<=1, mplier>>=1. No ALU request is made.
- RUN, mplier[0]==1: AluReq=1.
  - If AluGnt: acc<=AluResult, mcand<<=1, mplier>>=1.
  - Else: all registers hold (stall).
- DONE: done=1 for exactly one cycle, then go to IDLE.
- AluReq = (state==RUN) && mplier[0]. This is combinational and never depends on AluGnt.
- When AluReq=1: AluSrcA=acc, AluSrcB=mcand, AluOperation=ALU_ADD (4'b0010).
- Otherwise: AluSrcA=0, AluSrcB=0, AluOperation=ALU_AND (4'b0000).
- Arithmetic is modulo 2^DATA_WIDTH.
  - Bits shifted out of mcand are discarded.
  - The ALU adder carry is discarded.
  - The low half is identical for signed operands; no sign handling is required.
- start while ready=0 is ignored and not queued.
- AluGnt while AluReq=0 is ignored.
- Reset at any time: state=IDLE, acc/mcand/mplier/Product=0, no done pulse. An in-flight multiply is abandoned.

## Timing
- Reset values: ready=1, done=0, Product=0, AluReq=0, AluSrcA=0, AluSrcB=0, AluOperation=0.
- Start accepted at edge 0. RUN occupies cycles 1 through k+1. done is high in cycle k+2.
- k is the highest set bit index of MulB plus 1 (k=0 for MulB=0). Each cycle with AluReq=1 and AluGnt=0 adds one cycle.
- Latency with no stalls: minimum 2 (MulB=0), maximum DATA_WIDTH+2 (MulB MSB set).
- ready returns to 1 the cycle after done. Back-to-back starts are therefore spaced at least 3 cycles apart.
- AluSrcA, AluSrcB and AluOperation are stable throughout a stall.
- Product changes only on the edge that enters DONE.

## Structure
- Shared package alu_pkg holds:
  - ALU opcode constants ALU_AND=4'b0000, ALU_ADD=4'b0010, ALU_EQ=4'b0110, ALU_LT=4'b0111
  - state enum typedef (IDLE, RUN, DONE)
- There is no sub-module. The ALU and the operand mux stay outside this block.
- The bench instantiates alu (DATA_WIDTH=32) driven from AluSrcA, AluSrcB and AluOperation, with AluResult fed back.

## Test plan
- MulA=7, MulB=6, AluGnt=1 → Product=42. done in cycle 5 after start. AluReq high in exactly 2 cycles.
- MulA=0x1234, MulB=0 → Product=0, done in cycle 2, AluReq never asserted.
- MulA=0xFFFFFFFF, MulB=0xFFFFFFFF, AluGnt=1 → Product=0x00000001, done in cycle 34.
- MulA=3, MulB=5, AluGnt=0 for the first 4 AluReq cycles → Product=15, done in cycle 9. AluSrcA=0, AluSrcB=3 and AluOperation=0010 held throughout the stall.
- start pulsed during RUN with other operands → ignored. The first result is unaffected and no second done appears.
- reset asserted mid-RUN → ready=1, Product=0, no done pulse. A subsequent MulA=2, MulB=2 yields 4.
